// File: rtl/latch_ctrl_pkg.sv
// Shared state encoding, default sizes and width helper for the latch bank
// write controller and its arbiter.
package latch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        OPEN,
        HOLD,
        CLEAR
    } state_t;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_WIDTH = 8;

    // Index width for n items, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after i_ptr,
// wrapping modulo N_REQ.
module rr_arbiter
    import latch_ctrl_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]           i_req,
    input  logic [addr_w(N_REQ)-1:0]   i_ptr,
    output logic [N_REQ-1:0]           o_gnt,
    output logic [addr_w(N_REQ)-1:0]   o_idx,
    output logic                       o_valid
);

    localparam int PW = addr_w(N_REQ);

    int w_cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= N_REQ) w_cand = w_cand - N_REQ;
            for (int j = 0; j < N_REQ; j++) begin
                if (!o_valid && (w_cand == j) && i_req[j]) begin
                    o_valid  = 1'b1;
                    o_idx    = PW'(j);
                    o_gnt[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Write controller for a latch bank: round-robin grant, setup/open/hold write
// sequence that keeps D stable around the transparent window, and bank clear.
module latch_bank_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter int               N_REQ = DEF_N_REQ,
    parameter int               DEPTH = DEF_DEPTH,
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [N_REQ-1:0]                  i_req,
    input  logic [N_REQ*addr_w(DEPTH)-1:0]    i_addr,
    input  logic [N_REQ*WIDTH-1:0]            i_wdata,
    input  logic                              i_clr_req,
    output logic [N_REQ-1:0]                  o_gnt,
    output logic                              o_err,
    output logic                              o_clr_done,
    output logic                              o_busy,
    output logic [WIDTH-1:0]                  o_lat_d,
    output logic [DEPTH-1:0]                  o_lat_ce,
    output logic [DEPTH-1:0]                  o_lat_sr,
    output logic [WIDTH-1:0]                  o_lat_srinit
);

    localparam int AW = addr_w(DEPTH);
    localparam int PW = addr_w(N_REQ);

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_win;
    logic [AW-1:0]   r_addr;

    logic [N_REQ-1:0] w_arb_gnt;
    logic [PW-1:0]    w_arb_idx;
    logic             w_arb_vld;
    logic [AW-1:0]    w_sel_addr;
    logic [WIDTH-1:0] w_sel_data;
    logic [DEPTH-1:0] w_ce;
    logic [N_REQ-1:0] w_win_oh;
    logic [PW-1:0]    w_ptr_nxt;
    logic             w_oor;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_vld)
    );

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_arb_gnt[i]) begin
                w_sel_addr = i_addr[i*AW +: AW];
                w_sel_data = i_wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // Out-of-range addresses decode to no word at all, so the bank is untouched.
    always_comb begin
        w_ce = '0;
        for (int w = 0; w < DEPTH; w++) begin
            if (r_addr == AW'(w)) w_ce[w] = 1'b1;
        end
    end

    always_comb begin
        w_win_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_win == PW'(i)) w_win_oh[i] = 1'b1;
        end
    end

    assign w_oor     = (32'(r_addr) >= 32'(DEPTH));
    assign w_ptr_nxt = (r_win == PW'(N_REQ - 1)) ? '0 : r_win + 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_win        <= '0;
            r_addr       <= '0;
            o_gnt        <= '0;
            o_err        <= 1'b0;
            o_clr_done   <= 1'b0;
            o_busy       <= 1'b0;
            o_lat_d      <= '0;
            o_lat_ce     <= '0;
            o_lat_sr     <= '0;
            o_lat_srinit <= INIT;
        end else begin
            o_gnt        <= '0;
            o_err        <= 1'b0;
            o_clr_done   <= 1'b0;
            o_lat_ce     <= '0;
            o_lat_sr     <= '0;
            o_lat_srinit <= INIT;
            case (r_state)
                IDLE: begin
                    if (i_clr_req) begin
                        r_state    <= CLEAR;
                        o_lat_sr   <= '1;
                        o_clr_done <= 1'b1;
                        o_busy     <= 1'b1;
                    end else if (w_arb_vld) begin
                        // D moves only here, a full cycle before CE can rise.
                        r_state <= SETUP;
                        r_win   <= w_arb_idx;
                        r_addr  <= w_sel_addr;
                        o_lat_d <= w_sel_data;
                        o_busy  <= 1'b1;
                    end
                end
                SETUP: begin
                    r_state  <= OPEN;
                    o_lat_ce <= w_ce;
                end
                OPEN: begin
                    r_state <= HOLD;
                    o_gnt   <= w_win_oh;
                    o_err   <= w_oor;
                end
                HOLD: begin
                    r_state <= IDLE;
                    r_ptr   <= w_ptr_nxt;
                    o_busy  <= 1'b0;
                end
                CLEAR: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
